// File: rtl/design_sel_frontend.sv
// Pad-input front end: synchronises the raw pads and debounces the design-select pins.
// On every new selection it parks the pads on design 0 and holds the new design in reset before releasing it.
module design_sel_frontend #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1024,
   parameter int STRETCH_CYCLES  = 16
) (
   input  logic        clk_i,
   input  logic        rst_n,
   input  logic [41:0] io_in,
   input  logic [2:0]  sel_in,
   output logic [41:0] io_in_buffered,
   output logic [2:0]  design_sel_buffered,
   output logic        rst_override_n,
   output logic        sel_changed
);

   localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int SW = $clog2(STRETCH_CYCLES + 1);
   localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [SW-1:0] SCNT_LAST = SW'(STRETCH_CYCLES - 1);

   typedef enum logic [1:0] {ST_WAIT, ST_PARK, ST_HOLD, ST_RUN} state_t;

   logic [SYNC_STAGES-1:0][41:0] io_sync;
   logic [SYNC_STAGES-1:0][2:0]  sel_sync_chain;
   logic [2:0]                   sel_sync;
   logic [2:0]                   cand;
   logic [DW-1:0]                dcnt;
   logic [2:0]                   sel_stable;
   logic                         stable_valid;

   state_t        state, state_nxt;
   logic [SW-1:0] scnt, scnt_nxt;
   logic [2:0]    dsb_nxt;
   logic          rst_ovr_nxt;
   logic          chg_nxt;

   // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         io_sync        <= '0;
         sel_sync_chain <= '0;
      end else begin
         io_sync        <= {io_sync[SYNC_STAGES-2:0], io_in};
         sel_sync_chain <= {sel_sync_chain[SYNC_STAGES-2:0], sel_in};
      end
   end

   assign io_in_buffered = io_sync[SYNC_STAGES-1];
   assign sel_sync       = sel_sync_chain[SYNC_STAGES-1];

   // Any disagreement restarts the count; the counter saturates once the value is accepted.
   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         cand         <= '0;
         dcnt         <= '0;
         sel_stable   <= '0;
         stable_valid <= 1'b0;
      end else if (sel_sync != cand) begin
         cand <= sel_sync;
         dcnt <= '0;
      end else if (dcnt != DCNT_LAST) begin
         dcnt <= dcnt + 1'b1;
      end else begin
         sel_stable   <= cand;
         stable_valid <= 1'b1;
      end
   end

   // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned (no latch).
   always_comb begin
      state_nxt   = state;
      scnt_nxt    = scnt;
      dsb_nxt     = design_sel_buffered;
      rst_ovr_nxt = rst_override_n;
      chg_nxt     = 1'b0;
      case (state)
         ST_WAIT: begin
            dsb_nxt     = '0;
            rst_ovr_nxt = 1'b0;
            if (stable_valid) begin
               state_nxt = ST_PARK;
               scnt_nxt  = '0;
            end
         end
         ST_PARK: begin
            dsb_nxt     = '0;
            rst_ovr_nxt = 1'b0;
            if (scnt == SCNT_LAST) begin
               dsb_nxt   = sel_stable;
               chg_nxt   = 1'b1;
               scnt_nxt  = '0;
               state_nxt = ST_HOLD;
            end else begin
               scnt_nxt = scnt + 1'b1;
            end
         end
         ST_HOLD: begin
            rst_ovr_nxt = 1'b0;
            if (sel_stable != design_sel_buffered) begin
               dsb_nxt   = '0;
               scnt_nxt  = '0;
               state_nxt = ST_PARK;
            end else if (scnt == SCNT_LAST) begin
               rst_ovr_nxt = 1'b1;
               state_nxt   = ST_RUN;
            end else begin
               scnt_nxt = scnt + 1'b1;
            end
         end
         ST_RUN: begin
            rst_ovr_nxt = 1'b1;
            // Drop reset and the selection together so the select never moves while released.
            if (sel_stable != design_sel_buffered) begin
               rst_ovr_nxt = 1'b0;
               dsb_nxt     = '0;
               scnt_nxt    = '0;
               state_nxt   = ST_PARK;
            end
         end
         default: state_nxt = ST_WAIT;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         state               <= ST_WAIT;
         scnt                <= '0;
         design_sel_buffered <= '0;
         rst_override_n      <= 1'b0;
         sel_changed         <= 1'b0;
      end else begin
         state               <= state_nxt;
         scnt                <= scnt_nxt;
         design_sel_buffered <= dsb_nxt;
         rst_override_n      <= rst_ovr_nxt;
         sel_changed         <= chg_nxt;
      end
   end

endmodule

// File: tb/tb_design_sel_frontend.sv
// Self-checking bench for design_sel_frontend with SYNC_STAGES=2, DEBOUNCE_CYCLES=4, STRETCH_CYCLES=3.
// Select behaviour is checked cycle by cycle; the pad path uses a vector table and a latency queue.
module tb_design_sel_frontend;

   localparam int SYNC = 2;

   logic        clk_i = 1'b0;
   logic        rst_n;
   logic [41:0] io_in;
   logic [2:0]  sel_in;
   logic [41:0] io_in_buffered;
   logic [2:0]  design_sel_buffered;
   logic        rst_override_n;
   logic        sel_changed;

   int vec_cnt = 0;
   int err_cnt = 0;

   typedef struct {
      logic [41:0] io;
      logic [41:0] exp;
   } io_vec_t;

   io_vec_t     io_tab[6];
   logic [41:0] sb_q[$];

   design_sel_frontend #(
      .SYNC_STAGES    (2),
      .DEBOUNCE_CYCLES(4),
      .STRETCH_CYCLES (3)
   ) dut (
      .clk_i              (clk_i),
      .rst_n              (rst_n),
      .io_in              (io_in),
      .sel_in             (sel_in),
      .io_in_buffered     (io_in_buffered),
      .design_sel_buffered(design_sel_buffered),
      .rst_override_n     (rst_override_n),
      .sel_changed        (sel_changed)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string name, input logic [41:0] act, input logic [41:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Advance n edges, checking all select-side outputs after each one.
   task automatic expect_run(input int n, input logic [2:0] dsb, input logic rov,
                             input logic chg, input string tag);
      for (int i = 0; i < n; i++) begin
         tick();
         check({tag, ".dsb"}, 42'(design_sel_buffered), 42'(dsb));
         check({tag, ".rst_ovr"}, 42'(rst_override_n), 42'(rov));
         check({tag, ".chg"}, 42'(sel_changed), 42'(chg));
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".io"}, io_in_buffered, 42'h0);
      check({tag, ".dsb"}, 42'(design_sel_buffered), 42'h0);
      check({tag, ".rst_ovr"}, 42'(rst_override_n), 42'h0);
      check({tag, ".chg"}, 42'(sel_changed), 42'h0);
   endtask

   initial begin
      io_tab[0] = '{io: 42'h2AAAAAAAAAA, exp: 42'h2AAAAAAAAAA};
      io_tab[1] = '{io: 42'h15555555555, exp: 42'h15555555555};
      io_tab[2] = '{io: 42'h3FFFFFFFFFF, exp: 42'h3FFFFFFFFFF};
      io_tab[3] = '{io: 42'h00000000000, exp: 42'h00000000000};
      io_tab[4] = '{io: 42'h20000000001, exp: 42'h20000000001};
      io_tab[5] = '{io: 42'h00FF00FF00F, exp: 42'h00FF00FF00F};

      // 1: power-up with design 5 selected, pads active during reset
      rst_n  = 1'b0;
      sel_in = 3'd5;
      io_in  = 42'h3FFFFFFFFFF;
      tick();
      check_all_zero("t1.rst0");
      tick();
      check_all_zero("t1.rst1");
      rst_n = 1'b1;
      io_in = 42'h0;
      expect_run(6, 3'd0, 1'b0, 1'b0, "t1.wait");
      check("t1.stable_e6", 42'(dut.sel_stable), 42'd0);
      expect_run(1, 3'd0, 1'b0, 1'b0, "t1.wait7");
      check("t1.stable_e7", 42'(dut.sel_stable), 42'd5);
      expect_run(3, 3'd0, 1'b0, 1'b0, "t1.park");
      expect_run(1, 3'd5, 1'b0, 1'b1, "t1.load");
      expect_run(2, 3'd5, 1'b0, 1'b0, "t1.hold");
      expect_run(1, 3'd5, 1'b1, 1'b0, "t1.run");

      // 2: three-cycle glitch to 6 is rejected
      sel_in = 3'd6;
      expect_run(3, 3'd5, 1'b1, 1'b0, "t2.glitch");
      sel_in = 3'd5;
      expect_run(10, 3'd5, 1'b1, 1'b0, "t2.after");
      check("t2.stable", 42'(dut.sel_stable), 42'd5);

      // 3: switch from 5 to 2 while running
      sel_in = 3'd2;
      expect_run(7, 3'd5, 1'b1, 1'b0, "t3.debounce");
      check("t3.stable", 42'(dut.sel_stable), 42'd2);
      expect_run(3, 3'd0, 1'b0, 1'b0, "t3.park");
      expect_run(1, 3'd2, 1'b0, 1'b1, "t3.load");
      expect_run(2, 3'd2, 1'b0, 1'b0, "t3.hold");
      expect_run(1, 3'd2, 1'b1, 1'b0, "t3.run");

      // 6: one-cycle reset in RUN, then the full bring-up repeats
      io_in = 42'h15555555555;
      expect_run(2, 3'd2, 1'b1, 1'b0, "t6.pre");
      rst_n = 1'b0;
      tick();
      check_all_zero("t6.rst");
      rst_n = 1'b1;
      io_in = 42'h0;
      expect_run(10, 3'd0, 1'b0, 1'b0, "t6.wait_park");
      expect_run(1, 3'd2, 1'b0, 1'b1, "t6.load");
      expect_run(2, 3'd2, 1'b0, 1'b0, "t6.hold");
      expect_run(1, 3'd2, 1'b1, 1'b0, "t6.run");

      // 4: selection moves to 7 while design 2 is in HOLD
      rst_n = 1'b0;
      tick();
      check_all_zero("t4.rst");
      rst_n = 1'b1;
      expect_run(5, 3'd0, 1'b0, 1'b0, "t4.wait_a");
      sel_in = 3'd7;
      expect_run(2, 3'd0, 1'b0, 1'b0, "t4.wait_b");
      check("t4.stable2", 42'(dut.sel_stable), 42'd2);
      expect_run(3, 3'd0, 1'b0, 1'b0, "t4.park1");
      expect_run(1, 3'd2, 1'b0, 1'b1, "t4.load2");
      expect_run(1, 3'd2, 1'b0, 1'b0, "t4.hold2");
      check("t4.stable7", 42'(dut.sel_stable), 42'd7);
      expect_run(3, 3'd0, 1'b0, 1'b0, "t4.park2");
      expect_run(1, 3'd7, 1'b0, 1'b1, "t4.load7");
      expect_run(2, 3'd7, 1'b0, 1'b0, "t4.hold7");
      expect_run(1, 3'd7, 1'b1, 1'b0, "t4.run7");

      // 5: pad path latency, scoreboarded against the vector table
      for (int i = 0; i < 6; i++) begin
         io_in = io_tab[i].io;
         sb_q.push_back(io_tab[i].exp);
         tick();
         if (sb_q.size() == SYNC) check($sformatf("t5.io[%0d]", i - 1), io_in_buffered, sb_q.pop_front());
      end
      while (sb_q.size() > 0) begin
         tick();
         check("t5.io_drain", io_in_buffered, sb_q.pop_front());
      end
      check("t5.dsb_undisturbed", 42'(design_sel_buffered), 42'd7);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
